uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART TX serializer between N byte requesters on the TX bit clock. It latches the winning requester's byte and drives the serializer's TXDATA and TX_RQ inputs. It watches TX_BUSY to sequence start and end of frame, and reports per-requester grant and completion. A start watchdog flags a serializer that never goes busy.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter: FSM states and default-sized index/counter types.
package uart_pkg;

  localparam int N_DEF         = 4;
  localparam int SIZE_DEF      = 8;
  localparam int START_TMO_DEF = 4;

  localparam int IDX_W = $clog2(N_DEF);
  localparam int TMO_W = $clog2(START_TMO_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    FRAME = 2'd2
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TMO_W-1:0] tmo_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority search: first set req bit starting at ptr, wrapping past N-1 to 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] NW = PW'(N);

  logic [PW-1:0] pos;

  // Scan from the farthest offset down so the nearest hit to ptr is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= NW) pos = pos - NW;
      if (req[pos[IW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX serializer between N byte requesters,
// with a start watchdog that gives up if the serializer never reports busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int SIZE      = SIZE_DEF,
  parameter int START_TMO = START_TMO_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N-1:0]    REQ,
  input  logic [N*SIZE-1:0] DATA,
  output logic [N-1:0]    GNT,
  output logic [N-1:0]    DONE,
  output logic            ERR,
  output logic            BUSY,
  output logic [SIZE-1:0] TXDATA,
  output logic            TX_RQ,
  input  logic            TX_BUSY
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(START_TMO) + 1;
  localparam logic [IW-1:0] LAST     = IW'(N - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TMO - 1);

  state_e          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx, cur, cur_nx;
  logic [TW-1:0]   tmo, tmo_nx;
  logic [SIZE-1:0] txdata_nx;
  logic            tx_rq_nx, err_nx;
  logic [N-1:0]    gnt_nx, done_nx;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  rr_pick #(.N(N)) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    cur_nx    = cur;
    tmo_nx    = tmo;
    txdata_nx = TXDATA;
    tx_rq_nx  = TX_RQ;
    gnt_nx    = '0;
    done_nx   = '0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (!TX_BUSY && pick_valid) begin
          txdata_nx        = DATA[pick_idx*SIZE +: SIZE];
          tx_rq_nx         = 1'b1;
          gnt_nx[pick_idx] = 1'b1;
          cur_nx           = pick_idx;
          ptr_nx           = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
          tmo_nx           = '0;
          state_nx         = START;
        end
      end
      START: begin
        // Drop the request on the first busy sample so the serializer cannot restart.
        if (TX_BUSY) begin
          tx_rq_nx = 1'b0;
          state_nx = FRAME;
        end else if (tmo == TMO_LAST) begin
          tx_rq_nx = 1'b0;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_nx = tmo + 1'b1;
        end
      end
      FRAME: begin
        if (!TX_BUSY) begin
          done_nx[cur] = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      ptr    <= '0;
      cur    <= '0;
      tmo    <= '0;
      TXDATA <= '0;
      TX_RQ  <= 1'b0;
      GNT    <= '0;
      DONE   <= '0;
      ERR    <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      cur    <= cur_nx;
      tmo    <= tmo_nx;
      TXDATA <= txdata_nx;
      TX_RQ  <= tx_rq_nx;
      GNT    <= gnt_nx;
      DONE   <= done_nx;
      ERR    <= err_nx;
      BUSY   <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: serializer model plus grant/done scoreboard.
module tb_uart_tx_arbiter;

  localparam int N         = 4;
  localparam int SIZE      = 8;
  localparam int START_TMO = 4;

  typedef struct {
    int             idx;
    logic [SIZE-1:0] data;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [N-1:0]      REQ = '0;
  logic [N*SIZE-1:0] DATA = '0;
  logic [N-1:0]      GNT, DONE;
  logic              ERR, BUSY, TX_RQ;
  logic [SIZE-1:0]   TXDATA;
  logic              TX_BUSY;

  logic            model_en = 1'b1;
  logic            busy_drv = 1'b0;
  logic            m_busy = 1'b0;
  logic [3:0]      m_cnt = '0;
  logic [SIZE-1:0] m_sh = '0;
  logic            txd = 1'b1;
  logic [9:0]      line = '0;

  exp_t gnt_q[$];
  exp_t done_q[$];
  int   checks = 0;
  int   passed = 0;
  int   done_cnt = 0;

  assign TX_BUSY = model_en ? m_busy : busy_drv;

  uart_tx_arbiter #(.N(N), .SIZE(SIZE), .START_TMO(START_TMO)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .REQ     (REQ),
    .DATA    (DATA),
    .GNT     (GNT),
    .DONE    (DONE),
    .ERR     (ERR),
    .BUSY    (BUSY),
    .TXDATA  (TXDATA),
    .TX_RQ   (TX_RQ),
    .TX_BUSY (TX_BUSY)
  );

  always #5 CLK = ~CLK;

  // Serializer model: start bit, 8 data bits LSB first, stop bit, then idle at stop level.
  always @(posedge CLK) begin
    if (!m_busy) begin
      if (model_en && TX_RQ) begin
        m_busy <= 1'b1;
        m_cnt  <= 4'd0;
        m_sh   <= TXDATA;
        txd    <= 1'b0;
      end
    end else if (m_cnt == 4'd9) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 4'd1;
      txd   <= (m_cnt == 4'd8) ? 1'b1 : m_sh[m_cnt[2:0]];
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      if (m_busy) line[m_cnt] = txd;
      if (m_busy && m_cnt == 4'd9) begin
        checks++;
        if (TX_RQ !== 1'b0) $display("FAIL end_of_frame_rq got TX_RQ=%b want 0", TX_RQ);
        else passed++;
      end
      if (GNT != '0) begin
        checks++;
        if (gnt_q.size() == 0) begin
          $display("FAIL gnt_unexpected got GNT=%b want none", GNT);
        end else begin
          e = gnt_q.pop_front();
          if (GNT !== (4'b0001 << e.idx) || TXDATA !== e.data || TX_RQ !== 1'b1 || DONE !== '0)
            $display("FAIL grant got GNT=%b TXDATA=%h TX_RQ=%b DONE=%b want GNT=%b TXDATA=%h TX_RQ=1 DONE=0",
                     GNT, TXDATA, TX_RQ, DONE, 4'b0001 << e.idx, e.data);
          else passed++;
          done_q.push_back(e);
        end
      end
      if (DONE != '0) begin
        checks++;
        if (done_q.size() == 0) begin
          $display("FAIL done_unexpected got DONE=%b want none", DONE);
        end else begin
          e = done_q.pop_front();
          if (DONE !== (4'b0001 << e.idx) || line !== {1'b1, e.data, 1'b0})
            $display("FAIL done got DONE=%b line=%b want DONE=%b line=%b",
                     DONE, line, 4'b0001 << e.idx, {1'b1, e.data, 1'b0});
          else passed++;
          done_cnt++;
        end
      end
      if (ERR && done_q.size() != 0) e = done_q.pop_front();
    end
  end

  task automatic push_exp(input int idx, input logic [SIZE-1:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    gnt_q.push_back(e);
  endtask

  task automatic run_until(input int target, input int budget);
    for (int k = 0; k < budget && done_cnt < target; k++) begin
      @(negedge CLK);
      if (GNT != '0) REQ = REQ & ~GNT;
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (done_cnt < target) $display("FAIL run_timeout got done=%0d want %0d", done_cnt, target);
    else passed++;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks += 6;
    if (GNT !== '0)    $display("FAIL reset_gnt got %b want 0", GNT);       else passed++;
    if (DONE !== '0)   $display("FAIL reset_done got %b want 0", DONE);     else passed++;
    if (ERR !== 1'b0)  $display("FAIL reset_err got %b want 0", ERR);       else passed++;
    if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY);     else passed++;
    if (TXDATA !== '0) $display("FAIL reset_txdata got %h want 0", TXDATA); else passed++;
    if (TX_RQ !== 1'b0) $display("FAIL reset_txrq got %b want 0", TX_RQ);   else passed++;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single;
    int target;
    target = done_cnt + 1;
    DATA[1*SIZE +: SIZE] = 8'hA5;
    push_exp(1, 8'hA5);
    REQ = 4'b0010;
    @(negedge CLK);
    checks += 2;
    if (GNT !== 4'b0010) $display("FAIL single_latency got GNT=%b want 0010", GNT); else passed++;
    if (BUSY !== 1'b1)   $display("FAIL single_busy got %b want 1", BUSY);         else passed++;
    REQ = '0;
    @(negedge CLK);
    checks++;
    if (GNT !== '0) $display("FAIL single_gnt_pulse got %b want 0", GNT); else passed++;
    run_until(target, 40);
    checks++;
    if (BUSY !== 1'b0) $display("FAIL single_idle got BUSY=%b want 0", BUSY); else passed++;
  endtask

  task automatic test_back_to_back;
    int target;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    target = done_cnt + 4;
    DATA = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < N; i++) push_exp(i, DATA[i*SIZE +: SIZE]);
    REQ = 4'b1111;
    run_until(target, 120);
  endtask

  task automatic test_fair_wrap;
    int target;
    DATA = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    target = done_cnt + 1;
    push_exp(2, 8'hC2);
    REQ = 4'b0100;
    run_until(target, 40);
    target = done_cnt + 2;
    push_exp(3, 8'hD3);
    push_exp(0, 8'hA0);
    REQ = 4'b1001;
    run_until(target, 70);
    target = done_cnt + 2;
    push_exp(1, 8'hB1);
    push_exp(0, 8'hA0);
    REQ = 4'b0011;
    run_until(target, 70);
  endtask

  task automatic test_start_timeout;
    int rq_cyc, err_cyc, done_cyc, target;
    rq_cyc = 0; err_cyc = 0; done_cyc = 0;
    model_en = 1'b0;
    busy_drv = 1'b0;
    DATA[0 +: SIZE] = 8'h5A;
    push_exp(0, 8'h5A);
    REQ = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (GNT != '0) REQ = REQ & ~GNT;
      if (TX_RQ) rq_cyc++;
      if (ERR) err_cyc++;
      if (DONE != '0) done_cyc++;
    end
    checks += 4;
    if (rq_cyc != START_TMO) $display("FAIL tmo_rq_cycles got %0d want %0d", rq_cyc, START_TMO); else passed++;
    if (err_cyc != 1)  $display("FAIL tmo_err_pulses got %0d want 1", err_cyc);  else passed++;
    if (done_cyc != 0) $display("FAIL tmo_done_pulses got %0d want 0", done_cyc); else passed++;
    if (BUSY !== 1'b0) $display("FAIL tmo_idle got BUSY=%b want 0", BUSY);        else passed++;
    model_en = 1'b1;
    target = done_cnt + 1;
    push_exp(0, 8'h5A);
    REQ = 4'b0001;
    run_until(target, 40);
  endtask

  task automatic test_reset_mid_frame;
    int  k, dn;
    logic gnt_seen;
    dn = 0;
    gnt_seen = 1'b0;
    DATA[1*SIZE +: SIZE] = 8'hC3;
    push_exp(1, 8'hC3);
    REQ = 4'b0010;
    for (k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (GNT != '0) REQ = REQ & ~GNT;
      if (m_busy && m_cnt == 4'd4) break;
    end
    checks++;
    if (k == 30) $display("FAIL rst_mid_reach got cycles=%0d want <30", k); else passed++;
    RST_N = 1'b0;
    #1;
    checks += 5;
    if (GNT !== '0)     $display("FAIL rst_mid_gnt got %b want 0", GNT);     else passed++;
    if (DONE !== '0)    $display("FAIL rst_mid_done got %b want 0", DONE);   else passed++;
    if (BUSY !== 1'b0)  $display("FAIL rst_mid_busy got %b want 0", BUSY);   else passed++;
    if (TX_RQ !== 1'b0) $display("FAIL rst_mid_txrq got %b want 0", TX_RQ); else passed++;
    if (TXDATA !== '0)  $display("FAIL rst_mid_txdata got %h want 0", TXDATA); else passed++;
    gnt_q.delete();
    done_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    DATA[2*SIZE +: SIZE] = 8'h7E;
    push_exp(2, 8'h7E);
    REQ = 4'b0100;
    for (k = 0; k < 20 && m_busy; k++) begin
      @(negedge CLK);
      if (GNT != '0) gnt_seen = 1'b1;
      if (DONE != '0) dn++;
    end
    checks += 2;
    if (gnt_seen !== 1'b0) $display("FAIL rst_mid_gnt_while_busy got 1 want 0"); else passed++;
    if (dn != 0) $display("FAIL rst_mid_stale_done got %0d want 0", dn); else passed++;
    run_until(done_cnt + 1, 40);
  endtask

  task automatic test_busy_after_reset;
    logic gnt_seen;
    int   target;
    gnt_seen = 1'b0;
    model_en = 1'b0;
    busy_drv = 1'b1;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    DATA = {8'h13, 8'h12, 8'h11, 8'h10};
    REQ = 4'b1111;
    repeat (6) begin
      @(negedge CLK);
      if (GNT != '0) gnt_seen = 1'b1;
    end
    checks += 2;
    if (gnt_seen !== 1'b0) $display("FAIL busy_rst_gnt got 1 want 0"); else passed++;
    if (BUSY !== 1'b0) $display("FAIL busy_rst_state got BUSY=%b want 0", BUSY); else passed++;
    target = done_cnt + 4;
    for (int i = 0; i < N; i++) push_exp(i, DATA[i*SIZE +: SIZE]);
    model_en = 1'b1;
    run_until(target, 120);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fair_wrap();
    test_start_timeout();
    test_reset_mid_frame();
    test_busy_after_reset();
    checks++;
    if (gnt_q.size() != 0 || done_q.size() != 0)
      $display("FAIL scoreboard_leftover got gnt=%0d done=%0d want 0 0", gnt_q.size(), done_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
